data_mem_ctrl: RTL and testbench

DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

---
 rtl/data_mem_ctrl.sv | 179 +++++++++++++++++
 tb/tb_data_mem_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : data_mem_ctrl
// Purpose : RV32I load/store data memory with a fixed, parameterised response
//           latency, lane steering, sign/zero extension and fault reporting.
// Rev     : 1.0  initial release
// ============================================================================
module data_mem_ctrl #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [2:0]            req_funct3,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_fault
);

  localparam int         c_WIDX     = ADDR_WIDTH - 2;
  localparam int         c_DEPTH    = 1 << c_WIDX;
  localparam logic [2:0] c_CNT_INIT = 3'((LATENCY > 1) ? (LATENCY - 2) : 0);

  localparam logic [1:0] c_ST_IDLE = 2'd0;
  localparam logic [1:0] c_ST_WAIT = 2'd1;
  localparam logic [1:0] c_ST_RESP = 2'd2;

  logic [1:0]        r_state;
  logic [2:0]        r_cnt;
  logic [31:0]       r_mem [c_DEPTH];
  logic [31:0]       r_pend_rdata;
  logic              r_pend_fault;
  logic [31:0]       r_rsp_rdata;
  logic              r_rsp_fault;

  logic [1:0]        w_state_nxt;
  logic [2:0]        w_cnt_nxt;
  logic              w_accept;
  logic              w_rsp_load;
  logic [c_WIDX-1:0] w_widx;
  logic [1:0]        w_lane;
  logic              w_is_byte;
  logic              w_is_half;
  logic              w_is_word;
  logic              w_illegal;
  logic              w_misalign;
  logic              w_fault;
  logic [31:0]       w_rword;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_load;
  logic [31:0]       w_result;
  logic [31:0]       w_wdata_sh;
  logic [3:0]        w_be;

  assign req_ready = (r_state == c_ST_IDLE) || (r_state == c_ST_RESP);
  assign rsp_valid = (r_state == c_ST_RESP);
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_fault = r_rsp_fault;

  assign w_accept = req_valid && req_ready;
  assign w_widx   = req_addr[ADDR_WIDTH-1:2];
  assign w_lane   = req_addr[1:0];
  assign w_rword  = r_mem[w_widx];

  // funct3 decode: size from [1:0], unsigned-load flag from [2]
  always_comb begin
    w_is_byte = (req_funct3[1:0] == 2'b00);
    w_is_half = (req_funct3[1:0] == 2'b01);
    w_is_word = (req_funct3[1:0] == 2'b10);
    if (req_we) begin
      w_illegal = req_funct3[2] || (req_funct3[1:0] == 2'b11);
    end else begin
      w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);
    end
    w_misalign = (w_is_half && w_lane[0]) || (w_is_word && (w_lane != 2'b00));
    w_fault    = w_illegal || w_misalign;
  end

  always_comb begin
    w_byte = w_rword[{w_lane, 3'b000} +: 8];
    w_half = w_lane[1] ? w_rword[31:16] : w_rword[15:0];
    case (req_funct3[1:0])
      2'b00:   w_load = req_funct3[2] ? {24'd0, w_byte} : {{24{w_byte[7]}}, w_byte};
      2'b01:   w_load = req_funct3[2] ? {16'd0, w_half} : {{16{w_half[15]}}, w_half};
      default: w_load = w_rword;
    endcase
    w_result = (req_we || w_fault) ? 32'd0 : w_load;
  end

  always_comb begin
    w_wdata_sh = req_wdata << {w_lane, 3'b000};
    if (w_is_byte) begin
      w_be = 4'b0001 << w_lane;
    end else if (w_is_half) begin
      w_be = 4'b0011 << w_lane;
    end else begin
      w_be = 4'b1111;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      c_ST_IDLE, c_ST_RESP: begin
        if (w_accept) begin
          if (LATENCY == 1) begin
            w_state_nxt = c_ST_RESP;
          end else begin
            w_state_nxt = c_ST_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end else begin
          w_state_nxt = c_ST_IDLE;
        end
      end
      c_ST_WAIT: begin
        if (r_cnt == 3'd0) begin
          w_state_nxt = c_ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 3'd1;
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_cnt_nxt   = 3'd0;
      end
    endcase
  end

  // Response registers load on the edge that enters RESP, so they hold until the next response
  assign w_rsp_load = (LATENCY == 1) ? w_accept : ((r_state == c_ST_WAIT) && (r_cnt == 3'd0));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= c_ST_IDLE;
      r_cnt        <= 3'd0;
      r_pend_rdata <= 32'd0;
      r_pend_fault <= 1'b0;
      r_rsp_rdata  <= 32'd0;
      r_rsp_fault  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_pend_rdata <= w_result;
        r_pend_fault <= w_fault;
      end
      if (w_rsp_load) begin
        if (LATENCY == 1) begin
          r_rsp_rdata <= w_result;
          r_rsp_fault <= w_fault;
        end else begin
          r_rsp_rdata <= r_pend_rdata;
          r_rsp_fault <= r_pend_fault;
        end
      end
    end
  end

  // Array is deliberately not reset; stores commit on the acceptance edge
  always_ff @(posedge clk) begin
    if (!rst && w_accept && req_we && !w_fault) begin
      for (int b = 0; b < 4; b++) begin
        if (w_be[b]) begin
          r_mem[w_widx][b*8 +: 8] <= w_wdata_sh[b*8 +: 8];
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_data_mem_ctrl
// Purpose : Scoreboard bench for data_mem_ctrl at LATENCY 1, 4 and 3.
// Rev     : 1.0  initial release
// ============================================================================
module tb_data_mem_ctrl;

  localparam int c_AW = 10;
  localparam int c_N  = 3;

  typedef struct {
    int          id;
    logic [31:0] rdata;
    logic        fault;
    int          cyc;
  } exp_t;

  typedef struct packed {
    logic        we;
    logic [2:0]  f3;
    logic [9:0]  a;
    logic [31:0] wd;
    logic [31:0] rd;
    logic        f;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            req_we = 1'b0;
  logic [2:0]      req_funct3 = 3'd0;
  logic [c_AW-1:0] req_addr = '0;
  logic [31:0]     req_wdata = 32'd0;
  logic [c_N-1:0]  req_valid = '0;
  logic [c_N-1:0]  req_ready;
  logic [c_N-1:0]  rsp_valid;
  logic [c_N-1:0]  rsp_fault;
  logic [31:0]     rsp_rdata [c_N];

  int   cyc = 0;
  int   n_chk = 0;
  int   n_pass = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic int lat_of(input int id);
    return (id == 0) ? 1 : ((id == 1) ? 4 : 3);
  endfunction

  for (genvar g = 0; g < c_N; g++) begin : g_dut
    data_mem_ctrl #(
      .ADDR_WIDTH(c_AW),
      .LATENCY((g == 0) ? 1 : ((g == 1) ? 4 : 3))
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_we    (req_we),
      .req_funct3(req_funct3),
      .req_addr  (req_addr),
      .req_wdata (req_wdata),
      .rsp_valid (rsp_valid[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_fault (rsp_fault[g])
    );

    always @(negedge clk) begin
      exp_t e;
      if (rsp_valid[g] !== 1'b0) begin
        chk($sformatf("rsp_expected dut%0d", g), 32'(sb_q.size() != 0), 32'd1);
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk($sformatf("rsp_id dut%0d", g), 32'(g), 32'(e.id));
          chk($sformatf("rsp_cycle dut%0d", g), 32'(cyc), 32'(e.cyc));
          chk($sformatf("rsp_rdata dut%0d", g), rsp_rdata[g], e.rdata);
          chk($sformatf("rsp_fault dut%0d", g), 32'(rsp_fault[g]), 32'(e.fault));
        end
      end
    end
  end

  // Called just after a falling edge; returns just after the acceptance edge.
  task automatic issue(input int id, input logic we, input logic [2:0] f3,
                       input logic [c_AW-1:0] a, input logic [31:0] wd,
                       input logic [31:0] exp_rd, input logic exp_f, input bit push,
                       output int acc_cyc, output int stalls);
    exp_t e;
    req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    req_valid[id] = 1'b1;
    stalls  = 0;
    acc_cyc = -1;
    while (req_ready[id] !== 1'b1 && stalls < 20) begin
      @(negedge clk);
      stalls++;
    end
    if (req_ready[id] !== 1'b1) begin
      chk($sformatf("accept_timeout dut%0d", id), 32'(req_ready[id]), 32'd1);
      req_valid[id] = 1'b0;
      return;
    end
    acc_cyc = cyc;
    if (push) begin
      e.id = id; e.rdata = exp_rd; e.fault = exp_f; e.cyc = cyc + lat_of(id);
      sb_q.push_back(e);
    end
    @(negedge clk);
  endtask

  task automatic op(input int id, input vec_t v);
    int ac, st;
    issue(id, v.we, v.f3, v.a, v.wd, v.rd, v.f, 1'b1, ac, st);
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) @(negedge clk);
  endtask

  // we, funct3, addr, wdata, expected rdata, expected fault
  vec_t c_V1 [20] = '{
    '{1'b1, 3'b010, 10'h010, 32'hDEADBEEF, 32'h00000000, 1'b0},
    '{1'b0, 3'b010, 10'h010, 32'h00000000, 32'hDEADBEEF, 1'b0},
    '{1'b1, 3'b000, 10'h013, 32'h00000080, 32'h00000000, 1'b0},
    '{1'b0, 3'b000, 10'h013, 32'h00000000, 32'hFFFFFF80, 1'b0},
    '{1'b0, 3'b100, 10'h013, 32'h00000000, 32'h00000080, 1'b0},
    '{1'b0, 3'b010, 10'h010, 32'h00000000, 32'h80ADBEEF, 1'b0},
    '{1'b1, 3'b001, 10'h011, 32'h00001234, 32'h00000000, 1'b1},
    '{1'b0, 3'b010, 10'h010, 32'h00000000, 32'h80ADBEEF, 1'b0},
    '{1'b0, 3'b010, 10'h012, 32'h00000000, 32'h00000000, 1'b1},
    '{1'b0, 3'b011, 10'h010, 32'h00000000, 32'h00000000, 1'b1},
    '{1'b1, 3'b100, 10'h010, 32'hFFFFFFFF, 32'h00000000, 1'b1},
    '{1'b0, 3'b010, 10'h010, 32'h00000000, 32'h80ADBEEF, 1'b0},
    '{1'b0, 3'b001, 10'h012, 32'h00000000, 32'hFFFF80AD, 1'b0},
    '{1'b0, 3'b101, 10'h010, 32'h00000000, 32'h0000BEEF, 1'b0},
    '{1'b1, 3'b010, 10'h014, 32'h11223344, 32'h00000000, 1'b0},
    '{1'b1, 3'b001, 10'h016, 32'hCAFE5678, 32'h00000000, 1'b0},
    '{1'b1, 3'b000, 10'h015, 32'hFFFFFF99, 32'h00000000, 1'b0},
    '{1'b0, 3'b010, 10'h014, 32'h00000000, 32'h56789944, 1'b0},
    '{1'b0, 3'b000, 10'h015, 32'h00000000, 32'hFFFFFF99, 1'b0},
    '{1'b0, 3'b100, 10'h017, 32'h00000000, 32'h00000056, 1'b0}
  };

  vec_t c_V4 [6] = '{
    '{1'b1, 3'b010, 10'h000, 32'h11111111, 32'h00000000, 1'b0},
    '{1'b1, 3'b010, 10'h004, 32'h22222222, 32'h00000000, 1'b0},
    '{1'b1, 3'b010, 10'h008, 32'h833333C3, 32'h00000000, 1'b0},
    '{1'b0, 3'b010, 10'h000, 32'h00000000, 32'h11111111, 1'b0},
    '{1'b0, 3'b010, 10'h004, 32'h00000000, 32'h22222222, 1'b0},
    '{1'b0, 3'b000, 10'h008, 32'h00000000, 32'hFFFFFFC3, 1'b0}
  };

  initial begin
    int acc [6];
    int stl [6];
    vec_t v;

    repeat (3) @(negedge clk);
    for (int g = 0; g < c_N; g++) begin
      chk($sformatf("reset rsp_valid dut%0d", g), 32'(rsp_valid[g]), 32'd0);
      chk($sformatf("reset rsp_rdata dut%0d", g), rsp_rdata[g], 32'd0);
      chk($sformatf("reset rsp_fault dut%0d", g), 32'(rsp_fault[g]), 32'd0);
    end
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < c_N; g++) begin
      chk($sformatf("post-reset req_ready dut%0d", g), 32'(req_ready[g]), 32'd1);
    end

    // LATENCY=1: every vector back-to-back, req_valid never dropped
    for (int i = 0; i < 20; i++) op(0, c_V1[i]);
    idle(3);
    chk("hold rsp_rdata dut0", rsp_rdata[0], 32'h00000056);
    chk("hold rsp_fault dut0", 32'(rsp_fault[0]), 32'd0);

    // LATENCY=4: back-to-back with req_valid held high
    for (int i = 0; i < 6; i++) begin
      v = c_V4[i];
      issue(1, v.we, v.f3, v.a, v.wd, v.rd, v.f, 1'b1, acc[i], stl[i]);
    end
    for (int i = 1; i < 6; i++) begin
      chk($sformatf("L4 accept spacing %0d", i), 32'(acc[i] - acc[i-1]), 32'd4);
      chk($sformatf("L4 ready-low cycles %0d", i), 32'(stl[i]), 32'd3);
    end
    idle(6);

    // LATENCY=3: reset in flight, reset priority over a store, data retention
    v = '{1'b1, 3'b010, 10'h020, 32'h0BADF00D, 32'h0, 1'b0};
    op(2, v);
    v = '{1'b0, 3'b010, 10'h020, 32'h0, 32'h0BADF00D, 1'b0};
    op(2, v);
    idle(4);
    issue(2, 1'b0, 3'b010, 10'h020, 32'h0, 32'h0, 1'b0, 1'b0, acc[0], stl[0]);
    rst = 1'b1;
    req_we = 1'b1; req_funct3 = 3'b010; req_addr = 10'h020; req_wdata = 32'hFFFFFFFF;
    req_valid[2] = 1'b1;
    @(negedge clk);
    chk("rst-mid rsp_valid dut2", 32'(rsp_valid[2]), 32'd0);
    chk("rst-mid rsp_rdata dut2", rsp_rdata[2], 32'd0);
    chk("rst-mid rsp_fault dut2", 32'(rsp_fault[2]), 32'd0);
    rst = 1'b0;
    req_valid[2] = 1'b0;
    @(negedge clk);
    chk("post-release req_ready dut2", 32'(req_ready[2]), 32'd1);
    idle(4);
    v = '{1'b0, 3'b010, 10'h020, 32'h0, 32'h0BADF00D, 1'b0};
    op(2, v);
    idle(5);

    chk("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got cycle %0d, expected completion", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
